// File: rtl/iob_dma_sched.sv
// rtl/iob_dma_sched.sv - multi-channel round-robin DMA burst scheduler
//
// Takes one descriptor (byte address, length in words, direction) per channel.
// It splits each transfer into bursts of at most 2^BURST_W words and issues them
// to a single burst engine, one burst in flight at a time. Channels are served
// round-robin.
//
// Optional feature: define IOB_DMA_SCHED_BOUNDARY_EN to keep every burst inside
// one 4 KiB page. When it is undefined, bursts are bounded only by the remaining
// length and the maximum burst size.
//
// Ports:
//   clk_i, arst_n_i, cke_i, rst_i       clock, async reset (low), clock enable, soft reset
//   cfg_valid_i/cfg_ready_o             per-channel descriptor handshake
//   cfg_addr_i/cfg_len_i/cfg_dir_i      packed per-channel descriptor fields
//   cmd_valid_o/cmd_ready_i             burst command handshake to the engine
//   cmd_addr_o/cmd_len_o/cmd_dir_o      burst fields, stable while cmd_valid_o is high
//   cmd_ch_o                            granted channel, doubles as stream mux select
//   cmpl_valid_i/cmpl_err_i             engine completion of the outstanding burst
//   ch_busy_o/ch_done_o/ch_err_o        per-channel status (done is a one-cycle pulse)
module iob_dma_sched #(
    parameter int N_CH       = 4,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 32,
    parameter int BURST_W    = 8,
    parameter int DATA_BYTES = 4,
    parameter int CH_W       = $clog2(N_CH) + ($clog2(N_CH) == 0)
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic                     cke_i,
    input  logic                     rst_i,
    input  logic [N_CH-1:0]          cfg_valid_i,
    output logic [N_CH-1:0]          cfg_ready_o,
    input  logic [N_CH*ADDR_W-1:0]   cfg_addr_i,
    input  logic [N_CH*LEN_W-1:0]    cfg_len_i,
    input  logic [N_CH-1:0]          cfg_dir_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [ADDR_W-1:0]        cmd_addr_o,
    output logic [BURST_W:0]         cmd_len_o,
    output logic                     cmd_dir_o,
    output logic [CH_W-1:0]          cmd_ch_o,
    input  logic                     cmpl_valid_i,
    input  logic                     cmpl_err_i,
    output logic [N_CH-1:0]          ch_busy_o,
    output logic [N_CH-1:0]          ch_done_o,
    output logic [N_CH-1:0]          ch_err_o
);
    localparam int OFF_W = $clog2(DATA_BYTES);
    // Compare width holds the remaining length, the max burst and a page's word count.
    localparam int CW_A = (LEN_W > BURST_W + 1) ? LEN_W : BURST_W + 1;
    localparam int CW   = (CW_A > 14) ? CW_A : 14;
    localparam logic [CW-1:0] MAX_BURST = CW'(1) << BURST_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [N_CH-1:0]     busy_q, err_q, done_q, dir_q;
    logic [ADDR_W-1:0]   addr_q [N_CH];
    logic [LEN_W-1:0]    rem_q  [N_CH];
    logic [CH_W-1:0]     last_q;

    // Round-robin pick: the lowest busy index above last_q wins; otherwise wrap
    // to the lowest busy index at or below last_q.
    logic                any_busy, hi_found, lo_found;
    logic [CH_W-1:0]     pick, hi_idx, lo_idx;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (busy_q[j]) begin
                if (j > int'(last_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = CH_W'(j);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = CH_W'(j);
                end
            end
        end
        any_busy = hi_found | lo_found;
        pick     = hi_found ? hi_idx : lo_idx;
    end

    // Length of the next burst for the picked channel.
    logic [CW-1:0] rem_w, blen_w;
`ifdef IOB_DMA_SCHED_BOUNDARY_EN
    logic [CW-1:0] page_w;
`endif

    always_comb begin
        rem_w  = CW'(rem_q[pick]);
        blen_w = (rem_w < MAX_BURST) ? rem_w : MAX_BURST;
`ifdef IOB_DMA_SCHED_BOUNDARY_EN
        page_w = (CW'(4096) - CW'(addr_q[pick][11:0])) >> OFF_W;
        if (page_w < blen_w) begin
            blen_w = page_w;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_busy)     state_d = S_ISSUE;
            S_ISSUE: if (cmd_ready_i)  state_d = S_WAIT;
            S_WAIT:  if (cmpl_valid_i) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
        end else if (rst_i) begin
            state_q <= S_IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    // Completion only counts in WAIT; a stray completion elsewhere is ignored.
    logic               cmpl_fire;
    logic [LEN_W-1:0]   rem_after;
    logic [ADDR_W-1:0]  addr_after;

    assign cmpl_fire  = (state_q == S_WAIT) && cmpl_valid_i;
    assign rem_after  = rem_q[cmd_ch_o] - LEN_W'(cmd_len_o);
    assign addr_after = addr_q[cmd_ch_o] + (ADDR_W'(cmd_len_o) << OFF_W);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            busy_q     <= '0;
            err_q      <= '0;
            done_q     <= '0;
            dir_q      <= '0;
            last_q     <= CH_W'(N_CH - 1);
            cmd_addr_o <= '0;
            cmd_len_o  <= '0;
            cmd_dir_o  <= 1'b0;
            cmd_ch_o   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                addr_q[c] <= '0;
                rem_q[c]  <= '0;
            end
        end else if (rst_i) begin
            busy_q     <= '0;
            err_q      <= '0;
            done_q     <= '0;
            dir_q      <= '0;
            last_q     <= CH_W'(N_CH - 1);
            cmd_addr_o <= '0;
            cmd_len_o  <= '0;
            cmd_dir_o  <= 1'b0;
            cmd_ch_o   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                addr_q[c] <= '0;
                rem_q[c]  <= '0;
            end
        end else if (cke_i) begin
            done_q <= '0;

            // The granted channel is always busy, so descriptor loads never
            // collide with the completion update below.
            for (int c = 0; c < N_CH; c++) begin
                if (cfg_valid_i[c] && !busy_q[c]) begin
                    addr_q[c] <= cfg_addr_i[c*ADDR_W +: ADDR_W] & ~ADDR_W'(DATA_BYTES - 1);
                    rem_q[c]  <= cfg_len_i[c*LEN_W +: LEN_W];
                    dir_q[c]  <= cfg_dir_i[c];
                    err_q[c]  <= 1'b0;
                    if (cfg_len_i[c*LEN_W +: LEN_W] != '0) begin
                        busy_q[c] <= 1'b1;
                    end else begin
                        done_q[c] <= 1'b1;
                    end
                end
            end

            if (state_q == S_IDLE && any_busy) begin
                cmd_addr_o <= addr_q[pick];
                cmd_len_o  <= (BURST_W + 1)'(blen_w);
                cmd_dir_o  <= dir_q[pick];
                cmd_ch_o   <= pick;
                last_q     <= pick;
            end

            if (cmpl_fire) begin
                if (cmpl_err_i) begin
                    err_q[cmd_ch_o]  <= 1'b1;
                    busy_q[cmd_ch_o] <= 1'b0;
                    done_q[cmd_ch_o] <= 1'b1;
                end else begin
                    addr_q[cmd_ch_o] <= addr_after;
                    rem_q[cmd_ch_o]  <= rem_after;
                    if (rem_after == '0) begin
                        busy_q[cmd_ch_o] <= 1'b0;
                        done_q[cmd_ch_o] <= 1'b1;
                    end
                end
            end
        end
    end

    assign cmd_valid_o = (state_q == S_ISSUE);
    assign cfg_ready_o = ~busy_q;
    assign ch_busy_o   = busy_q;
    assign ch_done_o   = done_q;
    assign ch_err_o    = err_q;

endmodule

// File: tb/tb_iob_dma_sched.sv
// tb/tb_iob_dma_sched.sv - self-checking bench for iob_dma_sched
module tb_iob_dma_sched;
    localparam int N_CH    = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 32;
    localparam int BURST_W = 8;
    localparam int DB      = 4;
    localparam int CH_W    = 2;
`ifdef IOB_DMA_SCHED_BOUNDARY_EN
    localparam bit BOUNDARY_EN = 1'b1;
`else
    localparam bit BOUNDARY_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   arst_n, cke, rst;
    logic [N_CH-1:0]        cfg_valid, cfg_ready, cfg_dir, ch_busy, ch_done, ch_err;
    logic [N_CH*ADDR_W-1:0] cfg_addr;
    logic [N_CH*LEN_W-1:0]  cfg_len;
    logic                   cmd_valid, cmd_ready, cmd_dir, cmpl_valid, cmpl_err;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [BURST_W:0]       cmd_len;
    logic [CH_W-1:0]        cmd_ch;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    iob_dma_sched #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_W(BURST_W), .DATA_BYTES(DB)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_addr_i(cfg_addr),
        .cfg_len_i(cfg_len), .cfg_dir_i(cfg_dir),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_addr_o(cmd_addr),
        .cmd_len_o(cmd_len), .cmd_dir_o(cmd_dir), .cmd_ch_o(cmd_ch),
        .cmpl_valid_i(cmpl_valid), .cmpl_err_i(cmpl_err),
        .ch_busy_o(ch_busy), .ch_done_o(ch_done), .ch_err_o(ch_err)
    );

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [31:0] len;
        logic        dir;
        int          err_at;
        int          n;
        logic [31:0] ea [2];
        int          el [2];
    } vec_t;

    vec_t tbl [5];

    function automatic vec_t mk(int ch, logic [31:0] a, logic [31:0] len, logic dir, int err_at,
                                int n, logic [31:0] a0, int l0, logic [31:0] a1, int l1);
        vec_t v;
        v.ch = ch; v.addr = a; v.len = len; v.dir = dir; v.err_at = err_at; v.n = n;
        v.ea[0] = a0; v.el[0] = l0; v.ea[1] = a1; v.el[1] = l1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cfg(input int ch, input logic [31:0] a, input logic [31:0] len, input logic dir);
        cfg_valid[ch] = 1'b1;
        cfg_addr[ch*ADDR_W +: ADDR_W] = a;
        cfg_len[ch*LEN_W +: LEN_W] = len;
        cfg_dir[ch] = dir;
    endtask

    task automatic run_vec(input vec_t v);
        logic fin;
        cfg_valid = '0;
        drive_cfg(v.ch, v.addr, v.len, v.dir);
        chk("cfg_ready_idle", cfg_ready[v.ch], 1'b1);
        tick();
        cfg_valid = '0;
        chk("busy_t1", ch_busy[v.ch], v.len != 0);
        chk("done_t1", ch_done[v.ch], v.len == 0);
        chk("err_clr_t1", ch_err[v.ch], 1'b0);
        if (v.n == 0) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("zero_no_cmd", cmd_valid, 1'b0);
                chk("zero_done_off", ch_done[v.ch], 1'b0);
            end
        end
        for (int k = 0; k < v.n; k++) begin
            tick();
            chk("cmd_valid", cmd_valid, 1'b1);
            chk("cmd_ch", cmd_ch, v.ch);
            chk("cmd_addr", cmd_addr, v.ea[k]);
            chk("cmd_len", cmd_len, v.el[k]);
            chk("cmd_dir", cmd_dir, v.dir);
            tick();
            chk("cmd_hold", {cmd_valid, cmd_addr, cmd_len}, {1'b1, v.ea[k], 9'(v.el[k])});
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            chk("cmd_drop", cmd_valid, 1'b0);
            tick();
            cmpl_valid = 1'b1;
            cmpl_err = (k == v.err_at);
            tick();
            cmpl_valid = 1'b0;
            cmpl_err = 1'b0;
            fin = (k == v.n - 1) || (k == v.err_at);
            chk("done_pulse", ch_done[v.ch], fin);
            chk("busy_after", ch_busy[v.ch], !fin);
            chk("ready_after", cfg_ready[v.ch], fin);
            chk("err_after", ch_err[v.ch], k == v.err_at);
            if (fin) begin
                tick();
                chk("done_off", ch_done[v.ch], 1'b0);
                chk("no_more_cmd", cmd_valid, 1'b0);
                tick();
                chk("no_more_cmd2", cmd_valid, 1'b0);
            end
        end
    endtask

    task automatic serve(output int ch, output logic [31:0] a, output int l);
        int w;
        w = 0;
        while (cmd_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("cmd_wait_bound", w < 20, 1'b1);
        ch = int'(cmd_ch);
        a = cmd_addr;
        l = int'(cmd_len);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
        cmpl_valid = 1'b1;
        tick();
        cmpl_valid = 1'b0;
    endtask

    // Reference model: per-channel transfer state plus whether a command is
    // offered or a burst is outstanding.
    logic [N_CH-1:0] m_busy, m_err, m_done;
    logic [31:0]     m_addr [N_CH];
    logic [31:0]     m_rem  [N_CH];
    logic [N_CH-1:0] m_dir;
    logic            m_cv, m_inf;
    logic [CH_W-1:0] m_ch;
    logic [31:0]     m_caddr;
    logic [BURST_W:0] m_len;
    logic            m_cdir;
    int              m_last;

    function automatic int burst_len(logic [31:0] a, logic [31:0] r);
        int l = (r > 256) ? 256 : int'(r);
        int p = BOUNDARY_EN ? (4096 - int'(a % 4096)) / DB : 256;
        if (p < l) l = p;
        return l;
    endfunction

    task automatic model_reset();
        m_busy = '0; m_err = '0; m_done = '0; m_dir = '0;
        m_cv = 1'b0; m_inf = 1'b0; m_ch = '0; m_caddr = '0; m_len = '0; m_cdir = 1'b0;
        m_last = N_CH - 1;
        for (int c = 0; c < N_CH; c++) begin
            m_addr[c] = '0;
            m_rem[c] = '0;
        end
    endtask

    task automatic model_step();
        logic [N_CH-1:0] busy0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!cke) return;
        busy0 = m_busy;
        m_done = '0;
        if (m_cv) begin
            if (cmd_ready) begin
                m_cv = 1'b0;
                m_inf = 1'b1;
            end
        end else if (m_inf) begin
            if (cmpl_valid) begin
                m_inf = 1'b0;
                if (cmpl_err) begin
                    m_err[m_ch] = 1'b1;
                    m_busy[m_ch] = 1'b0;
                    m_done[m_ch] = 1'b1;
                end else begin
                    m_addr[m_ch] = m_addr[m_ch] + 32'(m_len) * 32'(DB);
                    m_rem[m_ch] = m_rem[m_ch] - 32'(m_len);
                    if (m_rem[m_ch] == 0) begin
                        m_busy[m_ch] = 1'b0;
                        m_done[m_ch] = 1'b1;
                    end
                end
            end
        end else begin
            for (int i = 1; i <= N_CH; i++) begin
                int c = (m_last + i) % N_CH;
                if (busy0[c]) begin
                    m_cv = 1'b1;
                    m_ch = CH_W'(c);
                    m_caddr = m_addr[c];
                    m_len = (BURST_W + 1)'(burst_len(m_addr[c], m_rem[c]));
                    m_cdir = m_dir[c];
                    m_last = c;
                    break;
                end
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_valid[c] && !busy0[c]) begin
                m_addr[c] = (cfg_addr[c*ADDR_W +: ADDR_W] / DB) * DB;
                m_rem[c] = cfg_len[c*LEN_W +: LEN_W];
                m_dir[c] = cfg_dir[c];
                m_err[c] = 1'b0;
                if (m_rem[c] != 0) m_busy[c] = 1'b1;
                else m_done[c] = 1'b1;
            end
        end
    endtask

    initial begin
        int          rr_ch [4];
        logic [31:0] rr_a  [4];
        int          rr_l  [4];
        logic [N_CH-1:0] nb;
        logic [31:0] ra;
        int          sel;

        arst_n = 1'b0; cke = 1'b1; rst = 1'b0;
        cfg_valid = '0; cfg_addr = '0; cfg_len = '0; cfg_dir = '0;
        cmd_ready = 1'b0; cmpl_valid = 1'b0; cmpl_err = 1'b0;

        tbl[0] = mk(0, 32'h1000, 300, 1'b0, -1, 2, 32'h1000, 256, 32'h1400, 44);
        if (BOUNDARY_EN)
            tbl[1] = mk(1, 32'h0FF0, 16, 1'b1, -1, 2, 32'h0FF0, 4, 32'h1000, 12);
        else
            tbl[1] = mk(1, 32'h0FF0, 16, 1'b1, -1, 1, 32'h0FF0, 16, 32'h0, 0);
        tbl[2] = mk(3, 32'h0020, 0, 1'b0, -1, 0, 32'h0, 0, 32'h0, 0);
        tbl[3] = mk(1, 32'h2000, 300, 1'b1, 0, 1, 32'h2000, 256, 32'h0, 0);
        tbl[4] = mk(1, 32'h3003, 5, 1'b1, -1, 1, 32'h3000, 5, 32'h0, 0);

        @(negedge clk);
        tick();
        chk("rst_cfg_ready", cfg_ready, 4'hF);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_status", {ch_busy, ch_done, ch_err}, 12'h0);
        chk("rst_cmd_fields", {cmd_addr, cmd_len, cmd_dir, cmd_ch}, 44'h0);
        arst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Round-robin between two channels loaded together, with a rejected
        // descriptor on a busy channel.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("srst_cfg_ready", cfg_ready, 4'hF);
        drive_cfg(0, 32'h0000, 512, 1'b0);
        drive_cfg(2, 32'h8000, 512, 1'b1);
        tick();
        cfg_valid = '0;
        drive_cfg(0, 32'h4000, 7, 1'b1);
        chk("busy_reject_ready", cfg_ready[0], 1'b0);
        tick();
        cfg_valid = '0;
        for (int i = 0; i < 4; i++) serve(rr_ch[i], rr_a[i], rr_l[i]);
        chk("rr_ch0", rr_ch[0], 0);
        chk("rr_ch1", rr_ch[1], 2);
        chk("rr_ch2", rr_ch[2], 0);
        chk("rr_ch3", rr_ch[3], 2);
        chk("rr_addr", {rr_a[0], rr_a[1], rr_a[2], rr_a[3]}, {32'h0, 32'h8000, 32'h400, 32'h8400});
        for (int i = 0; i < 4; i++) chk("rr_len", rr_l[i], 256);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_no_extra_cmd", cmd_valid, 1'b0);
        end
        chk("rr_all_idle", ch_busy, 4'h0);

        // Asynchronous reset while a command is offered.
        drive_cfg(0, 32'h0040, 100, 1'b0);
        tick();
        cfg_valid = '0;
        tick();
        chk("pre_arst_cmd", cmd_valid, 1'b1);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_cmd_valid", cmd_valid, 1'b0);
        chk("arst_busy", ch_busy, 4'h0);
        chk("arst_cmd_addr", cmd_addr, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        cmpl_valid = 1'b1;
        tick();
        cmpl_valid = 1'b0;
        chk("stale_cmpl_done", ch_done, 4'h0);
        chk("stale_cmpl_busy", ch_busy, 4'h0);
        tick();
        chk("stale_cmpl_cmd", cmd_valid, 1'b0);

        // Randomized traffic against the reference model.
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nb = ~m_busy;
            chk("r_busy", ch_busy, m_busy);
            chk("r_ready", cfg_ready, nb);
            chk("r_err", ch_err, m_err);
            chk("r_done", ch_done, m_done);
            chk("r_cmd_valid", cmd_valid, m_cv);
            chk("r_cmd", {cmd_ch, cmd_dir, cmd_len, cmd_addr}, {m_ch, m_cdir, m_len, m_caddr});
            rst = ($urandom_range(0, 499) == 0);
            cke = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < N_CH; c++) begin
                cfg_valid[c] = ($urandom_range(0, 7) == 0);
                ra = $urandom;
                cfg_addr[c*ADDR_W +: ADDR_W] = ($urandom_range(0, 7) == 0) ? (32'hFFFF_F000 | (ra & 32'hFFF))
                                                                           : (ra & 32'h3FFF);
                sel = $urandom_range(0, 3);
                cfg_len[c*LEN_W +: LEN_W] = (sel == 0) ? 32'd0 :
                                            (sel == 1) ? 32'($urandom_range(1, 8)) :
                                            (sel == 2) ? 32'($urandom_range(9, 300)) :
                                                         32'($urandom_range(257, 700));
                cfg_dir[c] = 1'($urandom_range(0, 1));
            end
            cmd_ready = 1'($urandom_range(0, 1));
            cmpl_valid = ($urandom_range(0, 2) == 0);
            cmpl_err = ($urandom_range(0, 9) == 0);
            model_step();
            tick();
        end
        rst = 1'b0;
        cke = 1'b1;
        cfg_valid = '0;
        cmd_ready = 1'b0;
        cmpl_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
